// File: rtl/loopback_bist_ctrl.sv
// rtl/loopback_bist_ctrl.sv - PRBS7 loopback self-test controller for the MSK transceiver chain
// Drives the coder with PRBS7, self-synchronises to the CDR output and counts bit errors.
module loopback_bist_ctrl #(
  parameter int NUM_BITS  = 64,
  parameter int SYNC_SKIP = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic        inClock,
  input  logic        inReset,
  input  logic        inStart,
  input  logic        inAbort,
  input  logic        inCoderReady,
  output logic        outTxData,
  output logic        outTxEmpty,
  input  logic        inRxFlag,
  input  logic        inRxData,
  output logic        outBistMode,
  output logic        outBusy,
  output logic        outDone,
  output logic        outPass,
  output logic        outTimeout,
  output logic [15:0] outErrCount,
  output logic [15:0] outRxCount
);

  localparam int TOTAL = SYNC_SKIP + 7 + NUM_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] SEED_START  = CW'(SYNC_SKIP);
  localparam logic [CW-1:0] CMP_START   = CW'(SYNC_SKIP + 7);
  localparam logic [CW-1:0] LAST_STROBE = CW'(TOTAL - 1);
  localparam logic [TW-1:0] TIMER_END   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} stateType;

  stateType state;
  stateType nextState;

  logic [6:0]    txLfsr;
  logic [6:0]    rxLfsr;
  logic [CW-1:0] strobeCnt;
  logic [TW-1:0] timer;
  logic [15:0]   errCountNext;

  logic startRun;
  logic inRun;
  logic consume;
  logic accept;
  logic seedPhase;
  logic comparePhase;
  logic expBit;
  logic bitError;
  logic lastCompare;
  logic runComplete;
  logic timerExpired;

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Abort outranks completion and timeout; REPORT always lasts exactly one cycle.
  always_comb begin
    nextState   = state;
    startRun    = 1'b0;
    outBusy     = 1'b0;
    outBistMode = 1'b0;
    outDone     = 1'b0;
    outTxEmpty  = 1'b1;
    outTxData   = 1'b0;
    unique case (state)
      IDLE: begin
        if (inStart && !inAbort) begin
          nextState = RUN;
          startRun  = 1'b1;
        end
      end
      RUN: begin
        outBusy     = 1'b1;
        outBistMode = 1'b1;
        outTxEmpty  = 1'b0;
        outTxData   = txLfsr[6];
        if (inAbort) begin
          nextState = IDLE;
        end else if (runComplete || timerExpired) begin
          nextState = REPORT;
        end
      end
      REPORT: begin
        outBistMode = 1'b1;
        outDone     = 1'b1;
        nextState   = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign inRun        = (state == RUN);
  assign consume      = inRun && inCoderReady;
  assign accept       = inRun && inRxFlag && !inAbort;
  assign seedPhase    = (strobeCnt >= SEED_START) && (strobeCnt < CMP_START);
  assign comparePhase = (strobeCnt >= CMP_START);
  assign expBit       = rxLfsr[6] ^ rxLfsr[5];
  assign bitError     = comparePhase && (inRxData != expBit);
  assign lastCompare  = (strobeCnt == LAST_STROBE);
  assign runComplete  = accept && lastCompare;
  // A strobe landing on the terminal count clears the timer instead of expiring it.
  assign timerExpired = inRun && !inRxFlag && (timer == TIMER_END);

  assign errCountNext = (accept && bitError && (outErrCount != 16'hFFFF))
                      ? outErrCount + 16'd1 : outErrCount;

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      txLfsr      <= '0;
      rxLfsr      <= '0;
      strobeCnt   <= '0;
      timer       <= '0;
      outPass     <= 1'b0;
      outTimeout  <= 1'b0;
      outErrCount <= '0;
      outRxCount  <= '0;
    end else if (startRun) begin
      txLfsr      <= 7'h7F;
      rxLfsr      <= '0;
      strobeCnt   <= '0;
      timer       <= '0;
      outPass     <= 1'b0;
      outTimeout  <= 1'b0;
      outErrCount <= '0;
      outRxCount  <= '0;
    end else if (inRun) begin
      if (inAbort) begin
        outPass <= 1'b0;
      end else begin
        if (consume) begin
          txLfsr <= {txLfsr[5:0], txLfsr[6] ^ txLfsr[5]};
        end
        if (inRxFlag) begin
          timer     <= '0;
          strobeCnt <= strobeCnt + 1'b1;
          if (outRxCount != 16'hFFFF) begin
            outRxCount <= outRxCount + 16'd1;
          end
          // Compare phase shifts the expected bit so one bad bit costs one error.
          if (seedPhase) begin
            rxLfsr <= {rxLfsr[5:0], inRxData};
          end else if (comparePhase) begin
            rxLfsr <= {rxLfsr[5:0], expBit};
          end
          outErrCount <= errCountNext;
        end else if (timer != TIMER_END) begin
          timer <= timer + 1'b1;
        end
        if (runComplete) begin
          outPass <= (errCountNext == 16'd0);
        end
        if (timerExpired) begin
          outTimeout <= 1'b1;
          outPass    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_loopback_bist_ctrl.sv
// tb/tb_loopback_bist_ctrl.sv - bench for loopback_bist_ctrl against a PRBS7 sequence model
module tb_loopback_bist_ctrl;

  localparam int SKIP = 8;
  localparam int NB   = 64;
  localparam int TO   = 4096;

  logic        inClock = 1'b0;
  logic        inReset;
  logic        inStart;
  logic        inAbort;
  logic        inCoderReady;
  logic        inRxFlag;
  logic        inRxData;
  logic        outTxData;
  logic        outTxEmpty;
  logic        outBistMode;
  logic        outBusy;
  logic        outDone;
  logic        outPass;
  logic        outTimeout;
  logic [15:0] outErrCount;
  logic [15:0] outRxCount;

  loopback_bist_ctrl #(.NUM_BITS(NB), .SYNC_SKIP(SKIP), .TIMEOUT(TO)) dut (
    .inClock(inClock), .inReset(inReset), .inStart(inStart), .inAbort(inAbort),
    .inCoderReady(inCoderReady), .outTxData(outTxData), .outTxEmpty(outTxEmpty),
    .inRxFlag(inRxFlag), .inRxData(inRxData), .outBistMode(outBistMode),
    .outBusy(outBusy), .outDone(outDone), .outPass(outPass), .outTimeout(outTimeout),
    .outErrCount(outErrCount), .outRxCount(outRxCount)
  );

  always #5 inClock = ~inClock;

  typedef struct {
    int when;
    bit data;
    int idx;
  } retT;

  int vectors = 0;
  int miscompares = 0;

  bit prbsRef[127];
  retT pending[$];
  bit consumed[$];

  int doneCount;
  int doneCycle;
  int expErr;
  int delivered;
  int busyLost;
  logic [15:0] doneErr;
  logic [15:0] doneRx;
  logic donePass;
  logic doneTimeout;
  logic doneEmpty;
  logic abortEmpty;
  logic abortMode;

  // PRBS7 x^7+x^6+1 from an all-ones seed: o[n] = o[n-7] ^ o[n-6].
  task automatic buildModel();
    for (int n = 0; n < 7; n++) prbsRef[n] = 1'b1;
    for (int n = 7; n < 127; n++) prbsRef[n] = prbsRef[n-7] ^ prbsRef[n-6];
  endtask

  task automatic idleInputs();
    inStart = 0; inAbort = 0; inCoderReady = 0; inRxFlag = 0; inRxData = 0;
  endtask

  // Loopback channel: consumed bits come back on inRxFlag 5 cycles later, with optional drops/flips.
  task automatic runEngine(input int maxCycles, input int gap, input bit randReady,
                           input int dropLo, input int dropHi, input int flipOrd, input int flipPct,
                           input bit noReturn, input int flagAt, input int abortAt, input bit startInRun);
    int lastCons;
    int cmpOrd;
    bit flip;
    bit ready;
    retT r;
    lastCons = -1000000;
    doneCount = 0; doneCycle = -1; expErr = 0; delivered = 0; busyLost = 0;
    abortEmpty = 1'bx; abortMode = 1'bx;
    consumed.delete();
    pending.delete();
    for (int cyc = 0; cyc < maxCycles; cyc++) begin
      @(negedge inClock);
      if (cyc > 0 && outDone === 1'b1) begin
        doneCount++;
        doneCycle = cyc; doneErr = outErrCount; doneRx = outRxCount;
        donePass = outPass; doneTimeout = outTimeout; doneEmpty = outTxEmpty;
        break;
      end
      if (cyc == abortAt + 1) begin
        abortEmpty = outTxEmpty;
        abortMode = outBistMode;
      end
      if (cyc >= 1 && cyc <= abortAt && outBusy !== 1'b1) busyLost++;
      inStart = (cyc == 0) || (startInRun && cyc > 2 && cyc < abortAt && $urandom_range(0, 1) == 1);
      inAbort = (cyc == abortAt);
      ready = randReady ? ($urandom_range(0, 3) != 0) : ((cyc - lastCons) >= gap);
      inCoderReady = ready;
      if (ready && outTxEmpty === 1'b0) begin
        consumed.push_back(outTxData);
        lastCons = cyc;
        if (!noReturn) begin
          r.when = cyc + 5; r.data = outTxData; r.idx = consumed.size() - 1;
          pending.push_back(r);
        end
      end
      inRxFlag = 0;
      inRxData = 0;
      if (pending.size() > 0 && pending[0].when == cyc) begin
        r = pending.pop_front();
        if (!(r.idx >= dropLo && r.idx <= dropHi)) begin
          cmpOrd = delivered - (SKIP + 7);
          flip = (cmpOrd >= 0) && (cmpOrd < NB) &&
                 ((cmpOrd == flipOrd) || ($urandom_range(0, 99) < flipPct));
          if (flip) expErr++;
          inRxFlag = 1;
          inRxData = r.data ^ flip;
          delivered++;
        end
      end
      if (cyc == flagAt) begin
        inRxFlag = 1;
        inRxData = 0;
      end
    end
    idleInputs();
  endtask

  task automatic test_reset();
    inReset = 1;
    idleInputs();
    repeat (2) @(negedge inClock);
    vectors++; if (outTxData !== 1'b0) begin miscompares++; $display("FAIL reset_txData: got %b want 0", outTxData); end
    vectors++; if (outTxEmpty !== 1'b1) begin miscompares++; $display("FAIL reset_txEmpty: got %b want 1", outTxEmpty); end
    vectors++; if (outBistMode !== 1'b0) begin miscompares++; $display("FAIL reset_bistMode: got %b want 0", outBistMode); end
    vectors++; if (outBusy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", outBusy); end
    vectors++; if (outDone !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", outDone); end
    vectors++; if (outPass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", outPass); end
    vectors++; if (outTimeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", outTimeout); end
    vectors++; if (outErrCount !== 16'd0) begin miscompares++; $display("FAIL reset_errCount: got %0d want 0", outErrCount); end
    vectors++; if (outRxCount !== 16'd0) begin miscompares++; $display("FAIL reset_rxCount: got %0d want 0", outRxCount); end
    inReset = 0;
    @(negedge inClock);
  endtask

  task automatic test_ideal_loopback();
    logic [7:0] first8;
    int bad;
    runEngine(2000, 0, 0, -1, -1, -1, 0, 0, -1, -1, 0);
    vectors++; if (doneCount !== 1) begin miscompares++; $display("FAIL ideal_doneCount: got %0d want 1", doneCount); end
    vectors++; if (doneCycle !== 85) begin miscompares++; $display("FAIL ideal_doneCycle: got %0d want 85", doneCycle); end
    vectors++; if (donePass !== 1'b1) begin miscompares++; $display("FAIL ideal_pass: got %b want 1", donePass); end
    vectors++; if (doneErr !== 16'd0) begin miscompares++; $display("FAIL ideal_errCount: got %0d want 0", doneErr); end
    vectors++; if (doneRx !== 16'(SKIP + 7 + NB)) begin miscompares++; $display("FAIL ideal_rxCount: got %0d want %0d", doneRx, SKIP + 7 + NB); end
    vectors++; if (doneTimeout !== 1'b0) begin miscompares++; $display("FAIL ideal_timeout: got %b want 0", doneTimeout); end
    vectors++; if (doneEmpty !== 1'b1) begin miscompares++; $display("FAIL ideal_txEmptyAtDone: got %b want 1", doneEmpty); end
    vectors++; if (consumed.size() !== SKIP + 7 + NB + 5) begin miscompares++; $display("FAIL ideal_consumedBits: got %0d want %0d", consumed.size(), SKIP + 7 + NB + 5); end
    first8 = 8'h00;
    for (int i = 0; i < 8 && i < consumed.size(); i++) first8[7-i] = consumed[i];
    vectors++; if (first8 !== 8'b1111_1110) begin miscompares++; $display("FAIL ideal_first8: got %b want 11111110", first8); end
    bad = 0;
    for (int i = 0; i < consumed.size(); i++) if (consumed[i] != prbsRef[i % 127]) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ideal_prbsStream: got %0d wrong bits want 0", bad); end
    @(negedge inClock);
    vectors++; if (outDone !== 1'b0 || outBistMode !== 1'b0) begin miscompares++; $display("FAIL ideal_afterReport: got done=%b mode=%b want 0/0", outDone, outBistMode); end
    vectors++; if (outPass !== 1'b1) begin miscompares++; $display("FAIL ideal_passHeld: got %b want 1", outPass); end
  endtask

  task automatic test_single_error();
    runEngine(4000, 0, 1, -1, -1, 19, 0, 0, -1, -1, 0);
    vectors++; if (doneCount !== 1) begin miscompares++; $display("FAIL single_doneCount: got %0d want 1", doneCount); end
    vectors++; if (doneErr !== 16'(expErr)) begin miscompares++; $display("FAIL single_errCount: got %0d want %0d", doneErr, expErr); end
    vectors++; if (donePass !== (expErr == 0)) begin miscompares++; $display("FAIL single_pass: got %b want %b", donePass, expErr == 0); end
  endtask

  task automatic test_random_errors();
    for (int run = 0; run < 3; run++) begin
      runEngine(4000, 0, 1, -1, -1, -1, 10, 0, -1, -1, 0);
      vectors++; if (doneErr !== 16'(expErr)) begin miscompares++; $display("FAIL random_errCount[%0d]: got %0d want %0d", run, doneErr, expErr); end
      vectors++; if (donePass !== (expErr == 0)) begin miscompares++; $display("FAIL random_pass[%0d]: got %b want %b", run, donePass, expErr == 0); end
      vectors++; if (doneRx !== 16'(SKIP + 7 + NB)) begin miscompares++; $display("FAIL random_rxCount[%0d]: got %0d want %0d", run, doneRx, SKIP + 7 + NB); end
    end
  endtask

  task automatic test_drop_gaps();
    runEngine(50000, 500, 0, 2, 4, -1, 0, 0, -1, -1, 0);
    vectors++; if (doneCount !== 1) begin miscompares++; $display("FAIL gaps_doneCount: got %0d want 1", doneCount); end
    vectors++; if (donePass !== 1'b1) begin miscompares++; $display("FAIL gaps_pass: got %b want 1", donePass); end
    vectors++; if (doneErr !== 16'd0) begin miscompares++; $display("FAIL gaps_errCount: got %0d want 0", doneErr); end
    vectors++; if (doneTimeout !== 1'b0) begin miscompares++; $display("FAIL gaps_timeout: got %b want 0", doneTimeout); end
  endtask

  task automatic test_timeout();
    runEngine(TO + 100, 0, 0, -1, -1, -1, 0, 1, -1, -1, 0);
    vectors++; if (doneCount !== 1) begin miscompares++; $display("FAIL timeout_doneCount: got %0d want 1", doneCount); end
    vectors++; if (doneCycle - 1 !== TO + 1) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", doneCycle - 1, TO + 1); end
    vectors++; if (doneTimeout !== 1'b1) begin miscompares++; $display("FAIL timeout_flag: got %b want 1", doneTimeout); end
    vectors++; if (donePass !== 1'b0) begin miscompares++; $display("FAIL timeout_pass: got %b want 0", donePass); end
    @(negedge inClock);
    vectors++; if (outTimeout !== 1'b1) begin miscompares++; $display("FAIL timeout_held: got %b want 1", outTimeout); end
  endtask

  task automatic test_timeout_race();
    runEngine(TO + 60, 0, 0, -1, -1, -1, 0, 1, TO + 1, TO + 50, 0);
    vectors++; if (doneCount !== 0) begin miscompares++; $display("FAIL race_doneCount: got %0d want 0", doneCount); end
    vectors++; if (busyLost !== 0) begin miscompares++; $display("FAIL race_busyLost: got %0d want 0", busyLost); end
    vectors++; if (outTimeout !== 1'b0) begin miscompares++; $display("FAIL race_timeout: got %b want 0", outTimeout); end
    vectors++; if (outRxCount !== 16'd1) begin miscompares++; $display("FAIL race_rxCount: got %0d want 1", outRxCount); end
  endtask

  task automatic test_abort();
    int extraDone;
    runEngine(40, 0, 0, -1, -1, -1, 0, 0, -1, 30, 1);
    vectors++; if (doneCount !== 0) begin miscompares++; $display("FAIL abort_doneCount: got %0d want 0", doneCount); end
    vectors++; if (busyLost !== 0) begin miscompares++; $display("FAIL abort_busyDuringRun: got %0d want 0", busyLost); end
    vectors++; if (abortEmpty !== 1'b1) begin miscompares++; $display("FAIL abort_txEmpty: got %b want 1", abortEmpty); end
    vectors++; if (abortMode !== 1'b0) begin miscompares++; $display("FAIL abort_bistMode: got %b want 0", abortMode); end
    vectors++; if (outPass !== 1'b0) begin miscompares++; $display("FAIL abort_pass: got %b want 0", outPass); end
    extraDone = 0;
    inStart = 1;
    inAbort = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge inClock);
      if (outDone === 1'b1) extraDone++;
      vectors++; if (outBusy !== 1'b0 || outBistMode !== 1'b0) begin miscompares++; $display("FAIL abort_startBlocked[%0d]: got busy=%b mode=%b want 0/0", i, outBusy, outBistMode); end
    end
    idleInputs();
    repeat (5) begin
      @(negedge inClock);
      if (outDone === 1'b1 || outBusy === 1'b1) extraDone++;
    end
    vectors++; if (extraDone !== 0) begin miscompares++; $display("FAIL abort_noExtraRun: got %0d want 0", extraDone); end
  endtask

  task automatic test_reset_midrun();
    runEngine(40, 0, 0, -1, -1, -1, 0, 0, -1, -1, 0);
    inReset = 1;
    #1;
    vectors++; if (outBusy !== 1'b0 || outBistMode !== 1'b0 || outTxEmpty !== 1'b1 || outTxData !== 1'b0) begin miscompares++; $display("FAIL midreset_ctrl: got busy=%b mode=%b empty=%b data=%b want 0/0/1/0", outBusy, outBistMode, outTxEmpty, outTxData); end
    vectors++; if (outErrCount !== 16'd0 || outRxCount !== 16'd0) begin miscompares++; $display("FAIL midreset_counts: got err=%0d rx=%0d want 0/0", outErrCount, outRxCount); end
    vectors++; if (outDone !== 1'b0 || outPass !== 1'b0 || outTimeout !== 1'b0) begin miscompares++; $display("FAIL midreset_result: got done=%b pass=%b to=%b want 0/0/0", outDone, outPass, outTimeout); end
    @(negedge inClock);
    inReset = 0;
    runEngine(2000, 0, 1, -1, -1, -1, 0, 0, -1, -1, 0);
    vectors++; if (doneCount !== 1) begin miscompares++; $display("FAIL midreset_doneCount: got %0d want 1", doneCount); end
    vectors++; if (donePass !== 1'b1) begin miscompares++; $display("FAIL midreset_pass: got %b want 1", donePass); end
  endtask

  initial begin
    buildModel();
    test_reset();
    test_ideal_loopback();
    test_single_error();
    test_random_errors();
    test_drop_gaps();
    test_timeout();
    test_timeout_race();
    test_abort();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loopback_bist_ctrl.md
# loopback_bist_ctrl

Built-in self-test controller for the MSK transceiver chain: inFIFO → coder → decoder → CORDIC → CDR → outFIFO.

- While a run is active it replaces the inFIFO as the coder's bit source and feeds a PRBS7 stream to the coder.
- It consumes the CDR's recovered bits, self-synchronises a reference PRBS7 to them, and counts bit errors.
- It reports pass/fail, error count and timeout to the test multiplexing logic at chip top.
- It also drives the override flag that steers the coder input and CDR output muxes to itself.

## Interface
Parameters:
- NUM_BITS, 64: compared bits per run (1..65535).
- SYNC_SKIP, 8: received bits discarded before seeding (covers decoder/CORDIC/CDR lock).
- TIMEOUT, 4096: maximum cycles allowed between consecutive inRxFlag strobes (and from run start to the first strobe).

Ports:
- inClock  in  1  single clock; all state is updated on its rising edge.
- inReset  in  1  asynchronous, active-high reset.
- inStart  in  1  run request; sampled only in IDLE.
- inAbort  in  1  stop an active run immediately.
- inCoderReady  in  1  coder o_ready; a bit is consumed in any cycle where inCoderReady=1 and outTxEmpty=0.
- outTxData  out  1  PRBS bit to the coder's i_data.
- outTxEmpty  out  1  to the coder's i_empty; 0 only in RUN.
- inRxFlag  in  1  CDR o_flag; inRxData is valid in that cycle.
- inRxData  in  1  CDR o_data.
- outBistMode  out  1  mux override; 1 in RUN and REPORT.
- outBusy  out  1  1 in RUN.
- outDone  out  1  one-cycle pulse in REPORT.
- outPass  out  1  last run result.
- outTimeout  out  1  last run ended on timeout.
- outErrCount  out  16  errors in last/current run, saturating at 16'hFFFF.
- outRxCount  out  16  strobes accepted in last/current run, saturating.

## Operation
States are IDLE, RUN and REPORT.
- IDLE → RUN: when inStart=1 and inAbort=0.
  - On entry: txLfsr=7'h7F, rxLfsr=0, all counters=0, outPass=0, outTimeout=0.
- RUN → REPORT: on the cycle the NUM_BITS-th compare is performed, or when the timeout counter reaches TIMEOUT.
- RUN → IDLE: on inAbort=1.
  - Aborting sets outPass=0 and does not pulse outDone.
  - Abort has priority over completion and over timeout.
- REPORT → IDLE: unconditionally after one cycle.
- inStart is ignored in RUN and REPORT.

PRBS7, polynomial x^7+x^6+1:
- Output bit is lfsr[6]; the next state is {lfsr[5:0], lfsr[6]^lfsr[5]}.
- From seed 7'h7F the first 8 transmitted bits are 1,1,1,1,1,1,1,0.

Transmit:
- In RUN, outTxData=txLfsr[6].
- txLfsr advances on each consumption (inCoderReady=1 and outTxEmpty=0).
- Transmission is continuous until RUN exits; there is no fixed transmit length.
- Outside RUN, outTxData=0 and outTxEmpty=1.

Receive: each inRxFlag in RUN increments outRxCount and is handled by phase.
- Skip phase, strobes 1..SYNC_SKIP: the bit is discarded.
- Seed phase, next 7 strobes: rxLfsr <= {rxLfsr[5:0], inRxData}.
- Compare phase, next NUM_BITS strobes:
  - exp = rxLfsr[6]^rxLfsr[5].
  - If inRxData != exp, outErrCount is incremented.
  - rxLfsr <= {rxLfsr[5:0], exp}; the expected bit is shifted, so a single error does not propagate.
- inRxFlag outside RUN is ignored.

Timeout counter:
- Cleared on RUN entry and on every accepted inRxFlag.
- Otherwise increments each RUN cycle.
- If inRxFlag and the terminal count occur in the same cycle, the strobe wins and no timeout is declared.

REPORT results:
- outPass = (outErrCount==0) && !outTimeout.
- outTimeout=1 only when the run ended on timeout.
- Results hold until the next accepted inStart or reset.

## Timing
- Reset values: state IDLE; outTxData 0; outTxEmpty 1; outBistMode 0; outBusy 0; outDone 0; outPass 0; outTimeout 0; outErrCount 0; outRxCount 0.
- Reset asserted mid-run returns the block to IDLE immediately; no outDone pulse.
- Start latency: inStart sampled at edge N gives outBusy=1, outTxEmpty=0 and outTxData=1 after edge N.
- Completion: the final compare strobe sampled at edge M gives outDone=1 for the cycle after edge M.
  - outTxEmpty=1 from that same cycle.
  - outPass, outErrCount and outRxCount are valid in the outDone cycle.
- Timeout path: with no strobes, outDone fires TIMEOUT+1 cycles after RUN entry.
- Abort: inAbort sampled at edge K gives IDLE, outTxEmpty=1, outBistMode=0 after edge K.
- Back-to-back consumption (inCoderReady held high) advances one PRBS bit per cycle.

## Test plan
- Ideal loopback (each consumed bit returned on inRxFlag 5 cycles later), defaults → outDone once, outPass=1, outErrCount=0, outRxCount=79; the first 8 consumed bits are 1111_1110.
- Same loopback, invert received bit #20 of the compare phase → outErrCount=1 exactly (no propagation), outPass=0.
- Drop 3 bits during the skip phase and insert 500-cycle gaps between strobes → outPass=1, outErrCount=0.
- Coder ready but no inRxFlag, TIMEOUT=4096 → outDone 4097 cycles after RUN entry, outTimeout=1, outPass=0; inRxFlag exactly at the terminal cycle → no timeout.
- inAbort at cycle 30 of RUN, inStart asserted during RUN, inStart+inAbort together in IDLE → no outDone, outTxEmpty=1 next cycle, no extra runs, start ignored.
- inReset pulsed mid-RUN → all outputs at reset values; a following inStart runs to outPass=1.
